seq_divider: RTL

//  Iterative unsigned restoring divider, one quotient bit per clock. Inverse

---
 rtl/seq_divider_pkg.sv | 15 +
 rtl/div_step.sv | 31 +++
 rtl/full_adder.sv | 14 +
 rtl/seq_divider.sv | 110 +++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types for the iterative restoring divider.
// FSM state encoding used by seq_divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/div_step.sv
// Combinational N+1-bit trial subtract T = a - {0,d} for one restoring step.
// Ripple of full_adder cells; borrow_o is T[N].
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   a_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N:0]   c;
  logic [N-1:0] nd;

  assign c[0] = 1'b1;
  assign nd   = ~d_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a_i(a_i[i]),
      .b_i(nd[i]),
      .c_i(c[i]),
      .s_o(diff_o[i]),
      .c_o(c[i+1])
    );
  end

  // Top stage subtracts a zero divisor bit, so T[N] = a[N] ^ 1 ^ c[N].
  assign borrow_o = ~(a_i[N] ^ c[N]);

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell from the ALU arithmetic group.
// Building block for the ripple subtractor in div_step.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Start/done handshake; results held until the next accepted start.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CNT_W = cnt_width(N);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [N-1:0]       r_q;
  logic [N-1:0]       q_q;
  logic [N-1:0]       d_q;
  logic [N-1:0]       quo_q;
  logic [N-1:0]       rem_q;
  logic               dbz_q;
  logic               busy_q;
  logic               done_q;

  logic [N:0]         trial;
  logic [N-1:0]       diff;
  logic               borrow;
  logic [N-1:0]       r_d;
  logic [N-1:0]       q_d;

  // R never exceeds the divisor, so its top bit is always zero and not stored.
  assign trial = {r_q, q_q[N-1]};

  div_step #(.N(N)) u_step (
    .a_i     (trial),
    .d_i     (d_q),
    .diff_o  (diff),
    .borrow_o(borrow)
  );

  assign r_d = borrow ? trial[N-1:0] : diff;
  assign q_d = {q_q[N-2:0], ~borrow};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          r_q <= r_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= q_d;
            rem_q   <= r_d;
            dbz_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          if (start) begin
            d_q <= divisor;
            r_q <= '0;
            q_q <= dividend;
            if (divisor == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              quo_q   <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_W'(N-1);
            end
          end
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
